// File: rtl/conv_pkg.sv
// Shared sizing helpers for the convolution adder tree: depth, result width and
// the per-level operand counts used to lay out the flattened tree bus.
package conv_pkg;

  function automatic int tree_stages(input int n);
    return ($clog2(n) < 1) ? 1 : $clog2(n);
  endfunction

  function automatic int sum_width(input int bitwidth, input int n);
    return bitwidth + tree_stages(n);
  endfunction

  // Operands present after `level` pairwise reductions (odd leftovers carried).
  function automatic int levelCount(input int n, input int level);
    int c = n;
    for (int i = 0; i < level; i++) c = (c + 1) / 2;
    return c;
  endfunction

  // Operand offset of `level` inside the bus that concatenates all levels.
  function automatic int levelOffset(input int n, input int level);
    int off = 0;
    for (int i = 0; i < level; i++) off += levelCount(n, i);
    return off;
  endfunction

endpackage

// File: rtl/adder_tree_stage.sv
// One registered pairwise-reduction level with a valid bit and stall handling.
// An odd trailing operand is forwarded unchanged to the last output slot.
module adder_tree_stage #(
  parameter int IN_COUNT   = 2,
  parameter int WIDTH      = 8,
  parameter bit CLEAR_DATA = 1'b0
) (
  input  logic                                clock,
  input  logic                                reset_n,
  input  logic [IN_COUNT*WIDTH-1:0]           inData,
  input  logic                                inValid,
  output logic                                inReady,
  output logic [((IN_COUNT+1)/2)*WIDTH-1:0]   outData,
  output logic                                outValid,
  input  logic                                outReady
);

  localparam int OUT_COUNT = (IN_COUNT + 1) / 2;

  logic [OUT_COUNT*WIDTH-1:0] nextData;

  for (genvar o = 0; o < OUT_COUNT; o++) begin : gPair
    if (2 * o + 1 < IN_COUNT) begin : gAdd
      assign nextData[o*WIDTH +: WIDTH] =
        inData[(2*o)*WIDTH +: WIDTH] + inData[(2*o+1)*WIDTH +: WIDTH];
    end else begin : gPass
      assign nextData[o*WIDTH +: WIDTH] = inData[(2*o)*WIDTH +: WIDTH];
    end
  end

  // The slot can load when it is empty or its content leaves this edge.
  assign inReady = !outValid || outReady;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      outValid <= 1'b0;
      if (CLEAR_DATA) outData <= '0;
    end else if (inReady) begin
      outValid <= inValid;
      if (inValid) outData <= nextData;
    end
  end

endmodule

// File: rtl/conv_adder_tree.sv
// Pipelined adder tree summing one CHANNELS x FILTER_WIDTH x FILTER_WIDTH window
// per cycle; a capture register feeds STAGES reduction levels, the last being sum.
module conv_adder_tree
  import conv_pkg::*;
#(
  parameter int BITWIDTH     = 8,
  parameter int FILTER_WIDTH = 3,
  parameter int CHANNELS     = 1,
  parameter int SIGNED       = 0,
  parameter int OUT_WIDTH    = 32
) (
  input  logic                                                       clock,
  input  logic                                                       reset_n,
  input  logic [CHANNELS-1:0][FILTER_WIDTH-1:0][FILTER_WIDTH-1:0][BITWIDTH-1:0] in_addends,
  input  logic                                                       in_valid,
  output logic                                                       in_ready,
  output logic [OUT_WIDTH-1:0]                                       sum,
  output logic                                                       sum_valid,
  input  logic                                                       sum_ready
);

  localparam int N      = CHANNELS * FILTER_WIDTH * FILTER_WIDTH;
  localparam int STAGES = tree_stages(N);
  localparam int SW     = sum_width(BITWIDTH, N);
  localparam int TOTAL  = levelOffset(N, STAGES + 1);

  if ((OUT_WIDTH < SW) || (N < 2)) begin : gBadParams
    $error("conv_adder_tree: OUT_WIDTH must be >= %0d and N must be >= 2", SW);
  end

  logic [N*BITWIDTH-1:0] flatAddends;
  logic [N*SW-1:0]       extAddends;
  logic [N*SW-1:0]       captureData;
  logic                  captureValid;
  logic [TOTAL*SW-1:0]   treeBus;
  logic [STAGES:0]       validBus;
  logic [STAGES+1:0]     readyBus;
  logic [SW-1:0]         finalSum;

  assign flatAddends = in_addends;

  for (genvar i = 0; i < N; i++) begin : gExtend
    if (SIGNED != 0) begin : gSigned
      assign extAddends[i*SW +: SW] =
        {{STAGES{flatAddends[i*BITWIDTH+BITWIDTH-1]}}, flatAddends[i*BITWIDTH +: BITWIDTH]};
    end else begin : gUnsigned
      assign extAddends[i*SW +: SW] = {{STAGES{1'b0}}, flatAddends[i*BITWIDTH +: BITWIDTH]};
    end
  end

  // Handshakes: a transfer happens on a rising edge where valid && ready are
  // both high; valid never waits on ready, and held data stays stable until taken.
  assign readyBus[STAGES+1] = sum_ready;
  assign readyBus[0]        = !captureValid || readyBus[1];
  assign validBus[0]        = captureValid;
  assign treeBus[N*SW-1:0]  = captureData;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      captureValid <= 1'b0;
    end else if (readyBus[0]) begin
      captureValid <= in_valid && in_ready;
      if (in_valid && in_ready) captureData <= extAddends;
    end
  end

  for (genvar l = 1; l <= STAGES; l++) begin : gLevel
    adder_tree_stage #(
      .IN_COUNT  (levelCount(N, l - 1)),
      .WIDTH     (SW),
      .CLEAR_DATA(l == STAGES)
    ) uStage (
      .clock   (clock),
      .reset_n (reset_n),
      .inData  (treeBus[levelOffset(N, l - 1)*SW +: levelCount(N, l - 1)*SW]),
      .inValid (validBus[l-1]),
      .inReady (readyBus[l]),
      .outData (treeBus[levelOffset(N, l)*SW +: levelCount(N, l)*SW]),
      .outValid(validBus[l]),
      .outReady(readyBus[l+1])
    );
  end

  assign finalSum = treeBus[levelOffset(N, STAGES)*SW +: SW];

  if (OUT_WIDTH > SW) begin : gWiden
    if (SIGNED != 0) begin : gSigned
      assign sum = {{(OUT_WIDTH-SW){finalSum[SW-1]}}, finalSum};
    end else begin : gUnsigned
      assign sum = {{(OUT_WIDTH-SW){1'b0}}, finalSum};
    end
  end else begin : gExact
    assign sum = finalSum;
  end

  // Reset forces the interface idle even before the first reset edge lands.
  assign sum_valid = reset_n && validBus[STAGES];
  assign in_ready  = !reset_n || !validBus[STAGES] || sum_ready;

endmodule

// File: tb/tb_conv_adder_tree.sv
// Bench for conv_adder_tree: unsigned 3x3, signed 3x3 and two-channel 3x3
// instances, with a scoreboard queue on the unsigned instance's output stream.
module tb_conv_adder_tree;

  logic clock;
  logic resetN;

  logic [0:0][2:0][2:0][7:0] uAddends;
  logic uValid, uInReady, uSumValid, uSumReady;
  logic [31:0] uSum;

  logic [0:0][2:0][2:0][7:0] sAddends;
  logic sValid, sInReady, sSumValid, sSumReady;
  logic [31:0] sSum;

  logic [1:0][2:0][2:0][7:0] cAddends;
  logic cValid, cInReady, cSumValid, cSumReady;
  logic [31:0] cSum;

  logic [31:0] exp_q[$];
  int popCyc[$];
  int cycleCount = 0;
  int nAssert = 0;
  int nFail = 0;

  conv_adder_tree dutU (
    .clock(clock), .reset_n(resetN), .in_addends(uAddends), .in_valid(uValid),
    .in_ready(uInReady), .sum(uSum), .sum_valid(uSumValid), .sum_ready(uSumReady)
  );

  conv_adder_tree #(.SIGNED(1)) dutS (
    .clock(clock), .reset_n(resetN), .in_addends(sAddends), .in_valid(sValid),
    .in_ready(sInReady), .sum(sSum), .sum_valid(sSumValid), .sum_ready(sSumReady)
  );

  conv_adder_tree #(.CHANNELS(2)) dutC (
    .clock(clock), .reset_n(resetN), .in_addends(cAddends), .in_valid(cValid),
    .in_ready(cInReady), .sum(cSum), .sum_valid(cSumValid), .sum_ready(cSumReady)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cycleCount <= cycleCount + 1;

  initial begin
    #200000;
    $error("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    nAssert++;
    assert (obs === expv) else begin
      nFail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // scoreboard on the unsigned instance
  always @(negedge clock) begin
    if (resetN && uSumValid && uSumReady) begin
      nAssert++;
      assert (exp_q.size() != 0) else begin
        nFail++;
        $error("FAIL spurious_result: observed %0h expected no result", uSum);
      end
      if (exp_q.size() != 0) begin
        check("sum_order", uSum, exp_q.pop_front());
        popCyc.push_back(cycleCount);
      end
    end
  end

  // driver tasks
  task automatic fillU(input logic [7:0] v);
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) uAddends[0][r][c] = v;
  endtask

  task automatic runStream(input int count, input int stallAt, input int stallLen, input bit rnd);
    int sent = 0;
    int cyc = 0;
    bit needNew = 1'b1;
    logic [31:0] expSum = '0;
    logic [31:0] held = '0;
    while ((sent < count || exp_q.size() != 0) && cyc < 300) begin
      @(posedge clock); #1;
      uSumReady = !(cyc >= stallAt && cyc < stallAt + stallLen);
      if (sent < count && needNew) begin
        expSum = '0;
        for (int r = 0; r < 3; r++)
          for (int c = 0; c < 3; c++) begin
            logic [7:0] a;
            a = rnd ? 8'($urandom_range(0, 255)) : 8'(sent + 1);
            uAddends[0][r][c] = a;
            expSum += 32'(a);
          end
        needNew = 1'b0;
      end
      uValid = (sent < count);
      @(negedge clock);
      if (cyc == stallAt) begin
        held = uSum;
        check("stall_sum_valid", 32'(uSumValid), 32'd1);
        check("stall_in_ready", 32'(uInReady), 32'd0);
      end else if (cyc > stallAt && cyc < stallAt + stallLen) begin
        check("stall_sum_hold", uSum, held);
        check("stall_in_ready", 32'(uInReady), 32'd0);
      end
      if (uValid && uInReady) begin
        exp_q.push_back(expSum);
        sent++;
        needNew = 1'b1;
      end
      cyc++;
    end
    @(posedge clock); #1;
    uValid = 1'b0;
    uSumReady = 1'b1;
    check("stream_sent", 32'(sent), 32'(count));
    check("stream_drained", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic sendS(input string tag, input logic [31:0] expv);
    int lat = 0;
    bit seen = 1'b0;
    @(posedge clock); #1;
    sValid = 1'b1;
    @(negedge clock);
    check({tag, "_in_ready"}, 32'(sInReady), 32'd1);
    @(posedge clock); #1;
    sValid = 1'b0;
    while (!seen && lat < 20) begin
      @(posedge clock); lat++;
      @(negedge clock);
      if (sSumValid) seen = 1'b1;
    end
    check({tag, "_latency"}, 32'(lat), 32'd4);
    check({tag, "_sum"}, sSum, expv);
  endtask

  task automatic sendC(input string tag, input logic [31:0] expv);
    int lat = 0;
    bit seen = 1'b0;
    @(posedge clock); #1;
    cValid = 1'b1;
    @(negedge clock);
    check({tag, "_in_ready"}, 32'(cInReady), 32'd1);
    @(posedge clock); #1;
    cValid = 1'b0;
    while (!seen && lat < 20) begin
      @(posedge clock); lat++;
      @(negedge clock);
      if (cSumValid) seen = 1'b1;
    end
    check({tag, "_latency"}, 32'(lat), 32'd5);
    check({tag, "_sum"}, cSum, expv);
  endtask

  initial begin
    int lat;
    bit seen;
    int stale;
    int mixed[9];
    mixed = '{1, -2, 3, -4, 5, -6, 7, -8, 9};

    resetN = 1'b0;
    uValid = 1'b0; sValid = 1'b0; cValid = 1'b0;
    uSumReady = 1'b1; sSumReady = 1'b1; cSumReady = 1'b1;
    fillU(8'd0);
    sAddends = '0;
    cAddends = '0;

    // reset state
    @(negedge clock);
    check("reset_in_ready", 32'(uInReady), 32'd1);
    check("reset_sum_valid", 32'(uSumValid), 32'd0);
    @(posedge clock);
    @(negedge clock);
    check("reset_sum_u", uSum, 32'd0);
    check("reset_sum_s", sSum, 32'd0);
    check("reset_sum_c", cSum, 32'd0);
    @(posedge clock); #1;
    resetN = 1'b1;

    // all 255, latency of four edges
    @(posedge clock); #1;
    fillU(8'd255);
    uValid = 1'b1;
    @(negedge clock);
    check("max_in_ready", 32'(uInReady), 32'd1);
    exp_q.push_back(32'd2295);
    @(posedge clock); #1;
    uValid = 1'b0;
    lat = 0;
    seen = 1'b0;
    while (!seen && lat < 20) begin
      @(posedge clock); lat++;
      @(negedge clock);
      if (uSumValid) seen = 1'b1;
    end
    check("max_latency", 32'(lat), 32'd4);
    check("max_sum", uSum, 32'd2295);
    @(posedge clock);
    @(negedge clock);
    check("max_drained", 32'(exp_q.size()), 32'd0);

    // ten back-to-back windows of value k
    popCyc.delete();
    runStream(10, 1000, 0, 1'b0);
    check("burst_count", 32'(popCyc.size()), 32'd10);
    if (popCyc.size() == 10)
      check("burst_consecutive", 32'(popCyc[9] - popCyc[0]), 32'd9);

    // random windows with a three-cycle downstream stall
    popCyc.delete();
    runStream(8, 6, 3, 1'b1);
    check("stall_count", 32'(popCyc.size()), 32'd8);

    // reset with three windows in flight
    @(posedge clock); #1;
    for (int k = 0; k < 3; k++) begin
      fillU(8'(20 + k));
      uValid = 1'b1;
      @(negedge clock);
      check("flight_accept", 32'(uInReady), 32'd1);
      @(posedge clock); #1;
    end
    uValid = 1'b0;
    resetN = 1'b0;
    @(negedge clock);
    check("midreset_in_ready", 32'(uInReady), 32'd1);
    check("midreset_sum_valid", 32'(uSumValid), 32'd0);
    @(posedge clock); #1;
    resetN = 1'b1;
    @(negedge clock);
    check("postreset_sum_valid", 32'(uSumValid), 32'd0);
    check("postreset_sum", uSum, 32'd0);
    stale = 0;
    repeat (12) begin
      @(negedge clock);
      if (uSumValid) stale++;
    end
    check("no_stale_result", 32'(stale), 32'd0);

    // signed instance
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) sAddends[0][r][c] = 8'h80;
    sendS("signed_min", 32'hFFFFFB80);
    for (int i = 0; i < 9; i++) sAddends[0][i/3][i%3] = 8'(mixed[i]);
    sendS("signed_mixed", 32'd5);

    // two-channel instance
    for (int ch = 0; ch < 2; ch++)
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++) cAddends[ch][r][c] = 8'd1;
    sendC("two_channel", 32'd18);

    repeat (3) @(posedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule
